// File: rtl/idu_ir_freelist_pkg.sv
// Shared IDU constants: physical register width, free-list depth and
// architectural register count. The rename-table entries and the free list
// both size themselves from these.
package idu_ir_freelist_pkg;

  localparam int PREG_W    = 6;   // physical register index width
  localparam int FL_DEPTH  = 32;  // free-list entries
  localparam int ARCH_REGS = 32;  // architectural registers (pregs 0..31 mapped at reset)
  localparam int IDX_W     = 5;   // log2(FL_DEPTH)
  localparam int PTR_W     = IDX_W + 1;  // index plus wrap bit

  // Pointer value of tail out of reset: the list starts completely full.
  localparam logic [PTR_W-1:0] TAIL_RST = PTR_W'(FL_DEPTH);

  // Preg held in entry i out of reset: the pregs not used by the arch map.
  function automatic logic [PREG_W-1:0] rst_entry(input int i);
    return PREG_W'(ARCH_REGS + i);
  endfunction

endpackage

// File: rtl/idu_ir_freelist.sv
// IR-stage physical register free list.
//
// A 32-entry circular buffer of preg indices with three 6-bit pointers
// (5-bit index + wrap bit):
//   spec_head   - next preg handed to rename (speculative)
//   commit_head - spec_head as it would be with only retired allocations
//   tail        - next slot written by a retiring instruction's old preg
// Every retire frees one preg and commits one allocation, so tail and
// commit_head advance together and tail - commit_head stays at 32.
//
// Handshake: alloc_vld is the valid (list non-empty, alloc_preg meaningful);
// the rename slot is ready when idu_alloc_req is high and the IR stage is
// neither stalled nor flushed. A transfer happens exactly when alloc_fire is
// high, and only then does spec_head move. alloc_vld/alloc_preg do not depend
// on the consumer side, so there is no combinational loop through them.
module idu_ir_freelist
  import idu_ir_freelist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              rtu_global_flush,
  input  logic              y_idu_ir_stall_ctrl,
  input  logic              idu_alloc_req,
  input  logic              rtu_retire_vld,
  input  logic [PREG_W-1:0] rtu_release_preg,
  output logic [PREG_W-1:0] alloc_preg,
  output logic              alloc_vld,
  output logic              alloc_fire,
  output logic [PTR_W-1:0]  free_cnt
);

  logic [PREG_W-1:0] entry_q [FL_DEPTH];
  logic [PTR_W-1:0]  spec_head_q;
  logic [PTR_W-1:0]  commit_head_q;
  logic [PTR_W-1:0]  tail_q;

  logic [PTR_W-1:0]  spec_head_nxt;
  logic [PTR_W-1:0]  commit_head_nxt;
  logic [PTR_W-1:0]  tail_nxt;

  // Head read, occupancy and allocation handshake (all zero latency).
  always_comb begin
    alloc_preg = entry_q[spec_head_q[IDX_W-1:0]];
    free_cnt   = tail_q - spec_head_q;
    alloc_vld  = (free_cnt != '0);
    alloc_fire = idu_alloc_req & alloc_vld & ~y_idu_ir_stall_ctrl & ~rtu_global_flush;
  end

  // Pointer next state. A flush rolls spec_head back to the committed point,
  // including a retire landing in the same cycle. A release written this
  // cycle is only visible at the head from the next cycle (no bypass).
  always_comb begin
    commit_head_nxt = commit_head_q;
    tail_nxt        = tail_q;
    if (rtu_retire_vld) begin
      commit_head_nxt = commit_head_q + PTR_W'(1);
      tail_nxt        = tail_q + PTR_W'(1);
    end

    spec_head_nxt = spec_head_q;
    if (rtu_global_flush) begin
      spec_head_nxt = commit_head_nxt;
    end else if (alloc_fire) begin
      spec_head_nxt = spec_head_q + PTR_W'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= TAIL_RST;
    end else begin
      spec_head_q   <= spec_head_nxt;
      commit_head_q <= commit_head_nxt;
      tail_q        <= tail_nxt;
    end
  end

  // Buffer storage: single write port at tail, reset to pregs 32..63.
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry_q[i] <= rst_entry(i);
      end
    end else if (rtu_retire_vld) begin
      entry_q[tail_q[IDX_W-1:0]] <= rtu_release_preg;
    end
  end

endmodule

// File: tb/tb_idu_ir_freelist.sv
// Bench for idu_ir_freelist: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences (fill/drain, empty+retire, flush,
// stall, wrap-around, flush+retire).
module tb_idu_ir_freelist;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_clk = 1'b0;
  logic       rtu_global_flush = 1'b0;
  logic       y_idu_ir_stall_ctrl = 1'b0;
  logic       idu_alloc_req = 1'b0;
  logic       rtu_retire_vld = 1'b0;
  logic [5:0] rtu_release_preg = 6'd0;
  logic [5:0] alloc_preg;
  logic       alloc_vld;
  logic       alloc_fire;
  logic [5:0] free_cnt;

  always #5 clk = ~clk;

  idu_ir_freelist dut (
    .clk                 (clk),
    .rst_clk             (rst_clk),
    .rtu_global_flush    (rtu_global_flush),
    .y_idu_ir_stall_ctrl (y_idu_ir_stall_ctrl),
    .idu_alloc_req       (idu_alloc_req),
    .rtu_retire_vld      (rtu_retire_vld),
    .rtu_release_preg    (rtu_release_preg),
    .alloc_preg          (alloc_preg),
    .alloc_vld           (alloc_vld),
    .alloc_fire          (alloc_fire),
    .free_cnt            (free_cnt)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic flush, input logic stall, input logic req,
                       input logic ret, input logic [5:0] rel);
    @(negedge clk);
    rtu_global_flush    = flush;
    y_idu_ir_stall_ctrl = stall;
    idu_alloc_req       = req;
    rtu_retire_vld      = ret;
    rtu_release_preg    = rel;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_clk             = 1'b0;
    rtu_global_flush    = 1'b0;
    y_idu_ir_stall_ctrl = 1'b0;
    idu_alloc_req       = 1'b0;
    rtu_retire_vld      = 1'b0;
    rtu_release_preg    = 6'd0;
    repeat (2) @(negedge clk);
    rst_clk = 1'b1;
  endtask

  task automatic chk_out(input string name, input logic [5:0] preg, input logic vld,
                         input logic fire, input logic [5:0] cnt);
    chk({name, ".preg"}, alloc_preg, preg);
    chk({name, ".vld"},  6'(alloc_vld), 6'(vld));
    chk({name, ".fire"}, 6'(alloc_fire), 6'(fire));
    chk({name, ".cnt"},  free_cnt, cnt);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       flush;
    logic       stall;
    logic       req;
    logic       ret;
    logic [5:0] rel;
    logic [5:0] e_preg;
    logic       e_vld;
    logic       e_fire;
    logic [5:0] e_cnt;
  } vec_t;

  function automatic vec_t mkv(input logic flush, input logic stall, input logic req,
                               input logic ret, input logic [5:0] rel,
                               input logic [5:0] e_preg, input logic e_vld,
                               input logic e_fire, input logic [5:0] e_cnt);
    vec_t v;
    v.flush = flush; v.stall = stall; v.req = req; v.ret = ret; v.rel = rel;
    v.e_preg = e_preg; v.e_vld = e_vld; v.e_fire = e_fire; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                flush stall req ret rel    preg vld fire cnt
    vecs[0]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd32, 1'b1, 1'b0, 6'd32); // reset state
    vecs[1]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd32, 1'b1, 1'b1, 6'd32); // alloc 32
    vecs[2]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  6'd33, 1'b1, 1'b0, 6'd31); // stalled
    vecs[3]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, 6'd0,  6'd33, 1'b1, 1'b0, 6'd31); // flush -> spec=0
    vecs[4]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd32, 1'b1, 1'b0, 6'd32); // rolled back
    vecs[5]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd32, 1'b1, 1'b1, 6'd32); // alloc 32
    vecs[6]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, 6'd9,  6'd33, 1'b1, 1'b1, 6'd31); // alloc 33 + retire 9
    vecs[7]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd34, 1'b1, 1'b0, 6'd31); // spec=2 tail=33
    vecs[8]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 6'd10, 6'd34, 1'b1, 1'b0, 6'd31); // flush+retire -> spec=2
    vecs[9]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd34, 1'b1, 1'b0, 6'd32); // commit=2 tail=34
    vecs[10] = mkv(1'b1, 1'b0, 1'b1, 1'b0, 6'd0,  6'd34, 1'b1, 1'b0, 6'd32); // flush blocks alloc
    vecs[11] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd34, 1'b1, 1'b0, 6'd32); // unchanged

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].flush, vecs[i].stall, vecs[i].req, vecs[i].ret, vecs[i].rel);
      chk_out($sformatf("vec%0d", i), vecs[i].e_preg, vecs[i].e_vld, vecs[i].e_fire, vecs[i].e_cnt);
    end

    // Fill/drain: 32 back-to-back allocations hand out 32..63 in order.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
      chk_out($sformatf("drain%0d", i), 6'(32 + i), 1'b1, 1'b1, 6'(32 - i));
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    chk("empty.vld",  6'(alloc_vld), 6'd0);
    chk("empty.fire", 6'(alloc_fire), 6'd0);
    chk("empty.cnt",  free_cnt, 6'd0);

    // Empty + retire: no bypass, released preg appears next cycle.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 6'd5);
    chk("nobypass.fire", 6'(alloc_fire), 6'd0);
    chk("nobypass.vld",  6'(alloc_vld), 6'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    chk_out("after_release", 6'd5, 1'b1, 1'b0, 6'd1);

    // Alloc 3, retire 1 (preg 7), flush -> spec=commit=1.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
      chk($sformatf("a3.preg%0d", i), alloc_preg, 6'(32 + i));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd7);
    chk("a3.retire_cnt", free_cnt, 6'd29);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
    chk("a3.flush_fire", 6'(alloc_fire), 6'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    chk_out("a3.post_flush", 6'd33, 1'b1, 1'b0, 6'd32);

    // Stall held 4 cycles with a request pending, then resume.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
      chk_out($sformatf("stall%0d", i), 6'd32, 1'b1, 1'b0, 6'd32);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    chk_out("resume", 6'd32, 1'b1, 1'b1, 6'd32);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    chk_out("resume_next", 6'd33, 1'b1, 1'b0, 6'd31);

    // 40 cycles of alloc+retire: count stays 32, pointers wrap, and the
    // preg released in cycle k comes back at the head in cycle k+32.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 6'(i));
      chk_out($sformatf("wrap%0d", i), (i < 32) ? 6'(32 + i) : 6'(i - 32), 1'b1, 1'b1, 6'd32);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    chk_out("wrap_end", 6'd8, 1'b1, 1'b0, 6'd32);

    // Flush + retire with 2 outstanding allocations -> spec = commit+1.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    chk("fr.pre_cnt", free_cnt, 6'd31);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 6'd20);
    chk_out("fr.flush_cycle", 6'd34, 1'b1, 1'b0, 6'd30);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    chk_out("fr.post", 6'd33, 1'b1, 1'b0, 6'd32);

    // Mid-operation reset restores the initial state.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 6'd3);
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    chk_out("rst_mid", 6'd32, 1'b1, 1'b0, 6'd32);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
